// File: rtl/user_obi_timer_bank.sv
// user_obi_timer_bank: OBI subordinate with a bank of compare timers.
// Optional per-channel prescaler: define USER_TIMER_PRESCALER_EN.
package user_obi_timer_pkg;
  localparam int unsigned NumExternalIrqs = 16;
  localparam int unsigned IdW = 4;

  typedef struct packed {
    logic [31:0]    addr;
    logic           we;
    logic [3:0]     be;
    logic [31:0]    wdata;
    logic [IdW-1:0] aid;
  } sbr_obi_a_t;

  typedef struct packed {
    logic       req;
    sbr_obi_a_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]    rdata;
    logic [IdW-1:0] rid;
    logic           err;
  } sbr_obi_r_t;

  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    sbr_obi_r_t r;
  } sbr_obi_rsp_t;
endpackage

module user_obi_timer_bank
  import user_obi_timer_pkg::*;
#(
  parameter int unsigned NumTimers   = 4,
  parameter int unsigned CntWidth    = 32,
  parameter int unsigned AddrOffsetW = 12,
  parameter logic [31:0] ErrRspData  = 32'hBADCAB1E
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       test_enable_i,
  input  sbr_obi_req_t               obi_req_i,
  output sbr_obi_rsp_t               obi_rsp_o,
  output logic [NumExternalIrqs-1:0] interrupts_o
);

  if (NumTimers < 1 || NumTimers > NumExternalIrqs) begin : g_bad_num
    $fatal(1, "NumTimers out of range");
  end
  if (CntWidth < 1 || CntWidth > 32) begin : g_bad_cnt
    $fatal(1, "CntWidth out of range");
  end
  if (AddrOffsetW < 6 || AddrOffsetW > 32) begin : g_bad_aw
    $fatal(1, "AddrOffsetW out of range");
  end

  localparam int unsigned ChW = AddrOffsetW - 5;

  logic [NumTimers-1:0] en_q, en_d;
  logic [NumTimers-1:0] per_q, per_d;
  logic [NumTimers-1:0] ien_q, ien_d;
  logic [NumTimers-1:0] pend_q, pend_d;
  logic [NumTimers-1:0][CntWidth-1:0] cnt_q, cnt_d;
  logic [NumTimers-1:0][CntWidth-1:0] cmp_q, cmp_d;
`ifdef USER_TIMER_PRESCALER_EN
  logic [NumTimers-1:0][7:0] psc_q, psc_d;
  logic [NumTimers-1:0][7:0] div_q, div_d;
`endif

  logic           rvalid_q, rvalid_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [IdW-1:0] rid_q, rid_d;
  logic           err_q, err_d;

  logic                   gnt, acc, wr;
  logic                   ch_ok, reg_ok;
  logic [AddrOffsetW-1:0] off;
  logic [ChW-1:0]         ch;
  logic [2:0]             rsel;
  int unsigned            ch_idx;
  logic [31:0]            rd_val;
  logic [31:0]            wdata;
  logic [3:0]             be;
  logic [NumTimers-1:0]   tick, match, wsel, w1c;
  logic                   unused_ok;

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] w,
    input logic [3:0]  b
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i+:8] = b[i] ? w[8*i+:8] : o[8*i+:8];
    end
    return r;
  endfunction

  assign gnt    = ~rst_i;
  assign acc    = obi_req_i.req & gnt;
  assign off    = obi_req_i.a.addr[AddrOffsetW-1:0];
  assign ch     = off[AddrOffsetW-1:5];
  assign rsel   = off[4:2];
  assign ch_idx = 32'(ch);
  assign ch_ok  = ch_idx < NumTimers;
  assign wdata  = obi_req_i.a.wdata;
  assign be     = obi_req_i.a.be;
  assign wr     = acc & ch_ok & reg_ok & obi_req_i.a.we;

  assign unused_ok = ^{test_enable_i, obi_req_i.a.addr, off[1:0]};

  // Register-select decode: which offsets inside a channel exist
  always_comb begin
    reg_ok = 1'b0;
    unique case (1'b1)
      (rsel == 3'd0): reg_ok = 1'b1;
      (rsel == 3'd1): reg_ok = 1'b1;
      (rsel == 3'd2): reg_ok = 1'b1;
      (rsel == 3'd3): reg_ok = 1'b1;
`ifdef USER_TIMER_PRESCALER_EN
      (rsel == 3'd4): reg_ok = 1'b1;
`endif
      default: reg_ok = 1'b0;
    endcase
  end

  // Per-channel tick, compare match, write select and W1C strobes
  always_comb begin
    tick  = '0;
    match = '0;
    wsel  = '0;
    w1c   = '0;
    for (int unsigned c = 0; c < NumTimers; c++) begin
`ifdef USER_TIMER_PRESCALER_EN
      tick[c] = en_q[c] & (div_q[c] == psc_q[c]);
`else
      tick[c] = en_q[c];
`endif
      match[c] = tick[c] & (cnt_q[c] == cmp_q[c]);
      wsel[c]  = wr & (ch_idx == c);
      w1c[c]   = wsel[c] & (rsel == 3'd3) & be[0] & wdata[0];
    end
  end

  // Channel next state: tick first, then bus writes override it
  always_comb begin
    en_d   = en_q;
    per_d  = per_q;
    ien_d  = ien_q;
    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    pend_d = pend_q;
`ifdef USER_TIMER_PRESCALER_EN
    psc_d  = psc_q;
    div_d  = div_q;
`endif
    for (int unsigned c = 0; c < NumTimers; c++) begin
      if (tick[c]) begin
        if (match[c]) begin
          if (per_q[c]) cnt_d[c] = '0;
          else          en_d[c]  = 1'b0;
        end else begin
          cnt_d[c] = cnt_q[c] + CntWidth'(1);
        end
      end
`ifdef USER_TIMER_PRESCALER_EN
      if (!en_q[c] || tick[c]) div_d[c] = '0;
      else                     div_d[c] = div_q[c] + 8'd1;
`endif
      if (wsel[c]) begin
        case (rsel)
          3'd0: begin
            if (be[0]) begin
              en_d[c]  = wdata[0];
              per_d[c] = wdata[1];
              ien_d[c] = wdata[2];
            end
`ifdef USER_TIMER_PRESCALER_EN
            div_d[c] = '0;
`endif
          end
          3'd1: begin
            if (|be) begin
              cnt_d[c] = CntWidth'(merge(32'(cnt_q[c]), wdata, be));
            end
          end
          3'd2: begin
            cmp_d[c] = CntWidth'(merge(32'(cmp_q[c]), wdata, be));
          end
`ifdef USER_TIMER_PRESCALER_EN
          3'd4: begin
            if (be[0]) psc_d[c] = wdata[7:0];
            div_d[c] = '0;
          end
`endif
          default: ;
        endcase
      end
      pend_d[c] = match[c] | (pend_q[c] & ~w1c[c]);
    end
  end

  // Read mux for the addressed channel register
  always_comb begin
    rd_val = '0;
    for (int unsigned c = 0; c < NumTimers; c++) begin
      if (ch_idx == c) begin
        case (rsel)
          3'd0: rd_val = {29'd0, ien_q[c], per_q[c], en_q[c]};
          3'd1: rd_val = 32'(cnt_q[c]);
          3'd2: rd_val = 32'(cmp_q[c]);
          3'd3: rd_val = {31'd0, pend_q[c]};
`ifdef USER_TIMER_PRESCALER_EN
          3'd4: rd_val = {24'd0, psc_q[c]};
`endif
          default: rd_val = '0;
        endcase
      end
    end
  end

  // Response next state: one-cycle latency, errors for unmapped space
  always_comb begin
    rvalid_d = acc;
    rid_d    = acc ? obi_req_i.a.aid : '0;
    err_d    = acc & ~(ch_ok & reg_ok);
    rdata_d  = '0;
    if (acc) begin
      if (err_d)                  rdata_d = ErrRspData;
      else if (!obi_req_i.a.we)   rdata_d = rd_val;
    end
  end

  // State and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q     <= '0;
      per_q    <= '0;
      ien_q    <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      cmp_q    <= '0;
`ifdef USER_TIMER_PRESCALER_EN
      psc_q    <= '0;
      div_q    <= '0;
`endif
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      per_q    <= per_d;
      ien_q    <= ien_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
`ifdef USER_TIMER_PRESCALER_EN
      psc_q    <= psc_d;
      div_q    <= div_d;
`endif
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
      err_q    <= err_d;
    end
  end

  // Level interrupts; channels beyond NumTimers stay low
  always_comb begin
    interrupts_o = '0;
    interrupts_o[NumTimers-1:0] = pend_q & ien_q;
  end

  assign obi_rsp_o.gnt     = gnt;
  assign obi_rsp_o.rvalid  = rvalid_q;
  assign obi_rsp_o.r.rdata = rdata_q;
  assign obi_rsp_o.r.rid   = rid_q;
  assign obi_rsp_o.r.err   = err_q;

endmodule

// File: tb/tb_user_obi_timer_bank.sv
// tb_user_obi_timer_bank: directed checks of the OBI timer bank.
// Prescaler scenario follows USER_TIMER_PRESCALER_EN.
module tb_user_obi_timer_bank;
  import user_obi_timer_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         test_en = 1'b0;
  sbr_obi_req_t req;
  sbr_obi_rsp_t rsp;
  logic [15:0]  irq;

  int total  = 0;
  int passed = 0;

  logic [31:0] t_rd;
  logic        t_er, t_v, t_g;
  logic [3:0]  t_id;

  user_obi_timer_bank dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .test_enable_i (test_en),
    .obi_req_i     (req),
    .obi_rsp_o     (rsp),
    .interrupts_o  (irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] a, input logic we,
                      input logic [3:0] be, input logic [31:0] wd,
                      input logic [3:0] aid);
    req.req     = 1'b1;
    req.a.addr  = a;
    req.a.we    = we;
    req.a.be    = be;
    req.a.wdata = wd;
    req.a.aid   = aid;
    t_g = rsp.gnt;
    @(posedge clk);
    #1;
    req.req = 1'b0;
    t_v  = rsp.rvalid;
    t_rd = rsp.r.rdata;
    t_er = rsp.r.err;
    t_id = rsp.r.rid;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(a, 1'b1, 4'hF, d, 4'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    xfer(a, 1'b0, 4'hF, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    logic [3:0] aid;
    req = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rsp.gnt, rsp.rvalid, rsp.r.err} !== 3'b000)
      $display("FAIL rst_rsp got %b want 000", {rsp.gnt, rsp.rvalid, rsp.r.err});
    else passed++;
    total++;
    if ({irq, rsp.r.rdata} !== 48'h0)
      $display("FAIL rst_irq_rdata got %h want 0", {irq, rsp.r.rdata});
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (rsp.gnt !== 1'b1) $display("FAIL rst_gnt got %b want 1", rsp.gnt);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      aid = 4'(i + 1);
      xfer(32'(4 * i), 1'b0, 4'hF, 32'h0, aid);
      total++;
      if ({t_g, t_v, t_er, t_id, t_rd} !== {1'b1, 1'b1, 1'b0, aid, 32'h0})
        $display("FAIL rst_read%0d got g%b v%b e%b id%h %h want g1 v1 e0 id%h 0",
                 i, t_g, t_v, t_er, t_id, t_rd, aid);
      else passed++;
    end
  endtask

  task automatic test_periodic();
    wr(32'h28, 32'd3);
    wr(32'h20, 32'h7);
    total++;
    if ({t_v, t_er, t_rd} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL per_wrrsp got v%b e%b %h want v1 e0 0", t_v, t_er, t_rd);
    else passed++;
    repeat (3) cyc();
    total++;
    if (irq !== 16'h0000) $display("FAIL per_pre got %h want 0000", irq);
    else passed++;
    cyc();
    total++;
    if (irq !== 16'h0002) $display("FAIL per_rise got %h want 0002", irq);
    else passed++;
    rd(32'h24);
    total++;
    if (t_rd !== 32'h0) $display("FAIL per_count got %h want 0", t_rd);
    else passed++;
    wr(32'h2C, 32'h1);
    total++;
    if (irq !== 16'h0000) $display("FAIL per_clr got %h want 0000", irq);
    else passed++;
    cyc();
    total++;
    if (irq !== 16'h0000) $display("FAIL per_gap got %h want 0000", irq);
    else passed++;
    cyc();
    total++;
    if (irq !== 16'h0002) $display("FAIL per_again got %h want 0002", irq);
    else passed++;
    wr(32'h20, 32'h0);
    wr(32'h2C, 32'h1);
  endtask

  task automatic test_oneshot();
    wr(32'h08, 32'd5);
    wr(32'h00, 32'h5);
    repeat (5) cyc();
    total++;
    if (irq !== 16'h0000) $display("FAIL os_pre got %h want 0000", irq);
    else passed++;
    cyc();
    total++;
    if (irq !== 16'h0001) $display("FAIL os_rise got %h want 0001", irq);
    else passed++;
    rd(32'h00);
    total++;
    if (t_rd !== 32'h4) $display("FAIL os_ctrl got %h want 4", t_rd);
    else passed++;
    rd(32'h04);
    total++;
    if (t_rd !== 32'd5) $display("FAIL os_count got %h want 5", t_rd);
    else passed++;
    repeat (2) cyc();
    rd(32'h04);
    total++;
    if (t_rd !== 32'd5) $display("FAIL os_hold got %h want 5", t_rd);
    else passed++;
    rd(32'h0C);
    total++;
    if (t_rd !== 32'h1) $display("FAIL os_status got %h want 1", t_rd);
    else passed++;
    wr(32'h0C, 32'h1);
    total++;
    if (irq !== 16'h0000) $display("FAIL os_clr got %h want 0000", irq);
    else passed++;
    rd(32'h0C);
    total++;
    if (t_rd !== 32'h0) $display("FAIL os_status0 got %h want 0", t_rd);
    else passed++;
  endtask

  task automatic test_error();
    rd(32'h80);
    total++;
    if ({t_v, t_er, t_rd} !== {1'b1, 1'b1, 32'hBADCAB1E})
      $display("FAIL err_ch got v%b e%b %h want v1 e1 badcab1e", t_v, t_er, t_rd);
    else passed++;
    rd(32'h14);
    total++;
    if ({t_er, t_rd} !== {1'b1, 32'hBADCAB1E})
      $display("FAIL err_reg got e%b %h want e1 badcab1e", t_er, t_rd);
    else passed++;
    wr(32'h80, 32'h7);
    total++;
    if ({t_er, t_rd} !== {1'b1, 32'hBADCAB1E})
      $display("FAIL err_wr got e%b %h want e1 badcab1e", t_er, t_rd);
    else passed++;
    wr(32'h14, 32'hFFFF_FFFF);
    rd(32'h00);
    total++;
    if ({t_er, t_rd} !== {1'b0, 32'h4})
      $display("FAIL err_nochg got e%b %h want e0 4", t_er, t_rd);
    else passed++;
    total++;
    if (irq !== 16'h0000) $display("FAIL err_irq got %h want 0000", irq);
    else passed++;
    xfer(32'h08, 1'b1, 4'h0, 32'hFF, 4'h2);
    total++;
    if ({t_er, t_id} !== {1'b0, 4'h2})
      $display("FAIL be0_rsp got e%b id%h want e0 id2", t_er, t_id);
    else passed++;
    rd(32'h08);
    total++;
    if (t_rd !== 32'd5) $display("FAIL be0_cmp got %h want 5", t_rd);
    else passed++;
    xfer(32'h08, 1'b1, 4'b0010, 32'h0000_AB00, 4'h0);
    rd(32'hFFFF_F008);
    total++;
    if ({t_er, t_rd} !== {1'b0, 32'h0000_AB05})
      $display("FAIL be_part got e%b %h want e0 0000ab05", t_er, t_rd);
    else passed++;
  endtask

  task automatic test_conflict();
    wr(32'h48, 32'd2);
    wr(32'h40, 32'h7);
    repeat (2) cyc();
    wr(32'h4C, 32'h1);
    total++;
    if (irq !== 16'h0004) $display("FAIL cf_w1c_match got %h want 0004", irq);
    else passed++;
    wr(32'h4C, 32'h1);
    total++;
    if (irq !== 16'h0000) $display("FAIL cf_w1c got %h want 0000", irq);
    else passed++;
    wr(32'h44, 32'h100);
    rd(32'h44);
    total++;
    if (t_rd !== 32'h100) $display("FAIL cf_cntwr got %h want 100", t_rd);
    else passed++;
    wr(32'h40, 32'h0);
    rd(32'h44);
    total++;
    if (t_rd !== 32'h102) $display("FAIL cf_cnt got %h want 102", t_rd);
    else passed++;
    total++;
    if (irq !== 16'h0000) $display("FAIL cf_irq got %h want 0000", irq);
    else passed++;
  endtask

  task automatic test_wrap();
    wr(32'h68, 32'h10);
    wr(32'h64, 32'hFFFF_FFFF);
    wr(32'h60, 32'h5);
    cyc();
    total++;
    if (irq !== 16'h0000) $display("FAIL wrap_irq got %h want 0000", irq);
    else passed++;
    rd(32'h64);
    total++;
    if (t_rd !== 32'h0) $display("FAIL wrap_cnt got %h want 0", t_rd);
    else passed++;
    rd(32'h6C);
    total++;
    if (t_rd !== 32'h0) $display("FAIL wrap_status got %h want 0", t_rd);
    else passed++;
    wr(32'h60, 32'h0);
  endtask

  task automatic test_prescale();
`ifdef USER_TIMER_PRESCALER_EN
    wr(32'h30, 32'd2);
    wr(32'h28, 32'd1);
    wr(32'h24, 32'd0);
    wr(32'h20, 32'h7);
    repeat (5) cyc();
    total++;
    if (irq !== 16'h0000) $display("FAIL psc_pre got %h want 0000", irq);
    else passed++;
    cyc();
    total++;
    if (irq !== 16'h0002) $display("FAIL psc_rise got %h want 0002", irq);
    else passed++;
    wr(32'h2C, 32'h1);
    total++;
    if (irq !== 16'h0000) $display("FAIL psc_clr got %h want 0000", irq);
    else passed++;
    repeat (4) cyc();
    total++;
    if (irq !== 16'h0000) $display("FAIL psc_gap got %h want 0000", irq);
    else passed++;
    cyc();
    total++;
    if (irq !== 16'h0002) $display("FAIL psc_again got %h want 0002", irq);
    else passed++;
    rd(32'h30);
    total++;
    if ({t_er, t_rd} !== {1'b0, 32'd2})
      $display("FAIL psc_read got e%b %h want e0 2", t_er, t_rd);
    else passed++;
    wr(32'h20, 32'h0);
    wr(32'h2C, 32'h1);
`else
    rd(32'h30);
    total++;
    if ({t_er, t_rd} !== {1'b1, 32'hBADCAB1E})
      $display("FAIL psc_rd_err got e%b %h want e1 badcab1e", t_er, t_rd);
    else passed++;
    wr(32'h30, 32'd2);
    total++;
    if ({t_er, t_rd} !== {1'b1, 32'hBADCAB1E})
      $display("FAIL psc_wr_err got e%b %h want e1 badcab1e", t_er, t_rd);
    else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    xfer(32'h08, 1'b0, 4'hF, 32'h0, 4'h5);
    total++;
    if ({t_v, t_id, t_rd} !== {1'b1, 4'h5, 32'h0000_AB05})
      $display("FAIL b2b0 got v%b id%h %h want v1 id5 0000ab05", t_v, t_id, t_rd);
    else passed++;
    xfer(32'h04, 1'b0, 4'hF, 32'h0, 4'h6);
    total++;
    if ({t_v, t_id, t_rd} !== {1'b1, 4'h6, 32'd5})
      $display("FAIL b2b1 got v%b id%h %h want v1 id6 5", t_v, t_id, t_rd);
    else passed++;
    xfer(32'h00, 1'b0, 4'hF, 32'h0, 4'h7);
    total++;
    if ({t_v, t_id, t_rd} !== {1'b1, 4'h7, 32'h4})
      $display("FAIL b2b2 got v%b id%h %h want v1 id7 4", t_v, t_id, t_rd);
    else passed++;
    cyc();
    total++;
    if (rsp.rvalid !== 1'b0) $display("FAIL b2b_idle got %b want 0", rsp.rvalid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    req.req     = 1'b1;
    req.a.addr  = 32'h04;
    req.a.we    = 1'b0;
    req.a.be    = 4'hF;
    req.a.aid   = 4'h9;
    @(posedge clk);
    #1;
    req.req = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({rsp.gnt, rsp.rvalid} !== 2'b00)
      $display("FAIL rm_rsp got %b want 00", {rsp.gnt, rsp.rvalid});
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    rd(32'h08);
    total++;
    if ({t_er, t_rd} !== {1'b0, 32'h0})
      $display("FAIL rm_cmp got e%b %h want e0 0", t_er, t_rd);
    else passed++;
    rd(32'h00);
    total++;
    if (t_rd !== 32'h0) $display("FAIL rm_ctrl got %h want 0", t_rd);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_error();
    test_conflict();
    test_wrap();
    test_prescale();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
